// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for EX-stage branch resolution: FSM states, PC step and
// RV32 branch funct3 encodings.
package branch_redirect_ctrl_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam int PC_INC = 4;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_t;

endpackage

// File: rtl/branch_redirect_ctrl_mispredict_counter.sv
// Saturating up-counter of branch mispredicts; sticks at all-ones.
module branch_redirect_ctrl_mispredict_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: compares the resolved branch with its prediction,
// holds a PC redirect plus front-end flushes until IF accepts it.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             ifu_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [CNT_W-1:0] mispredict_cnt
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] correct_pc;
    logic            resolve, mispredict;
    logic            upd_valid_q, upd_taken_q;
    logic [XLEN-1:0] upd_pc_q;

    // EX inputs are only trusted in IDLE; in REDIRECT they are wrong-path.
    assign resolve    = ex_valid & ex_is_branch & ~stall & (state_q == IDLE);
    assign mispredict = resolve & ((branch_taken != pred_taken) |
                        (branch_taken & pred_taken & (branch_target != pred_target)));
    assign correct_pc = branch_taken ? branch_target : ex_pc + XLEN'(PC_INC);

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = correct_pc;
                end
            end
            REDIRECT: begin
                if (ifu_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= resolve;
            if (resolve) begin
                upd_pc_q    <= ex_pc;
                upd_taken_q <= branch_taken;
            end
        end
    end

    branch_redirect_ctrl_mispredict_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (mispredict),
        .cnt   (mispredict_cnt)
    );

    // Redirect and flushes come straight from the state flop.
    assign redirect_valid = (state_q == REDIRECT);
    assign flush_if_id    = (state_q == REDIRECT);
    assign flush_id_ex    = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences branch resolution in the EX stage of the RV32IM pipeline. It takes the taken/not-taken result of the EX branch comparator and compares it with the IF-stage prediction. On a mismatch it issues a held PC redirect to IF and flushes the IF/ID and ID/EX registers until IF accepts the redirect. It also emits a one-cycle predictor-update pulse per resolved branch and keeps a saturating mispredict counter.

Parameters:
XLEN, 32, datapath/PC width
CNT_W, 16, width of saturating mispredict counter

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
stall  in  1  pipeline hold (e.g. mul/div busy); EX inputs are not sampled while high
ex_valid  in  1  EX holds a real instruction
ex_is_branch  in  1  EX instruction is branch/JAL/JALR
branch_taken  in  1  comparator result (JAL/JALR always 1)
ex_pc  in  XLEN  PC of EX instruction
branch_target  in  XLEN  computed target
pred_taken  in  1  prediction carried down the pipe
pred_target  in  XLEN  predicted target carried down the pipe
ifu_ready  in  1  IF accepts redirect this cycle
redirect_valid  out  1  redirect request to IF
redirect_pc  out  XLEN  correct next PC
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
upd_valid  out  1  predictor update pulse
upd_pc  out  XLEN  PC of resolved branch
upd_taken  out  1  resolved direction
mispredict_cnt  out  CNT_W  saturating count of mispredicts

Behaviour:
- Resolve event R = ex_valid & ex_is_branch & ~stall & (state==IDLE).
- Mispredict M = R & ((branch_taken != pred_taken) | (branch_taken & pred_taken & branch_target != pred_target)).
- Correct PC: branch_target if branch_taken, else ex_pc+4, modulo 2^XLEN (0xFFFFFFFC+4 wraps to 0x0).
- All outputs are registered. Latency is 1 cycle: an event sampled at edge t appears after edge t.
- FSM states: IDLE, REDIRECT.
- IDLE -> REDIRECT on M. redirect_pc latched, redirect_valid=1, flush_if_id=1, flush_id_ex=1.
- REDIRECT: redirect_valid, redirect_pc and both flushes are held stable. EX inputs are ignored (wrong-path or bubble). stall does not affect REDIRECT.
- REDIRECT -> IDLE on the edge where redirect_valid & ifu_ready. The next cycle has redirect_valid=0 and flushes=0. ifu_ready may be high in the first REDIRECT cycle, giving a one-cycle redirect.
- ifu_ready is ignored in IDLE.
- upd_valid=1 for exactly one cycle after every R, with or without a mispredict; upd_pc=ex_pc, upd_taken=branch_taken. upd_valid is 0 otherwise; upd_pc/upd_taken hold their last value.
- mispredict_cnt increments by 1 per M and saturates at 2^CNT_W-1.
- A stalled branch is evaluated once, on the first edge with stall=0; it is never counted twice.
- Correctly predicted branch: no redirect, no flush, state stays IDLE.
- Reset (any state, including mid-REDIRECT): state=IDLE, and redirect_valid, flush_if_id, flush_id_ex, upd_valid, upd_taken = 0. redirect_pc, upd_pc and mispredict_cnt reset to 0.

Decomposition:
- Shared encodings/include file: FSM state localparams (IDLE=1'b0, REDIRECT=1'b1) and the PC increment constant 4, alongside the existing branch op encodings.
- One natural sub-module: mispredict_counter (saturating up-counter, CNT_W parameter, synchronous reset, inc input).

Test Plan:
- Reset, then BEQ at ex_pc=0x100, taken=1, pred_taken=1, targets equal 0x140 -> upd_valid pulse (upd_pc=0x100, upd_taken=1); redirect_valid=0; flushes=0; cnt=0.
- Branch at 0x200, taken=0, pred_taken=1, ifu_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x204, both flushes=1 for exactly 1 cycle; cnt=1.
- Branch at 0x300, taken=1, target 0x380, pred_taken=0, ifu_ready low 3 cycles then high -> redirect_valid and flushes held 4 cycles with redirect_pc=0x380; a valid branch presented in EX meanwhile produces no upd_valid.
- JALR at 0x400, taken=1, pred_taken=1, target 0x500 vs pred_target 0x600 -> redirect to 0x500, cnt+1. Second case: stall high 2 cycles with a mispredicting branch, then low -> a single redirect and a single upd_valid, starting the cycle after stall falls.
- Not-taken mispredict at ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000. CNT_W=2: 4 mispredicts -> cnt sticks at 3.
- RESET asserted in the 2nd REDIRECT cycle -> next cycle redirect_valid=0, flushes=0, cnt=0, state IDLE. The following correctly predicted branch resolves normally.
